prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/prefetch_unit.sv | 153 +++++++++++++++
 tb/tb_prefetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_unit
// Purpose  : Instruction prefetch queue. Streams sequential reads from a
//            one-cycle-latency instruction memory into a small FIFO that
//            feeds decode, with branch redirect and program-download
//            suspension.
// Ports    : clk, reset_n          - clock, synchronous active-low reset
//            download_program     - suspends fetching, empties the queue
//            mem_rd_en/mem_index  - memory read request and index
//            mem_data             - read data, one cycle after the request
//            instr_valid/ready    - decode handshake for the queue head
//            instr/instr_index    - head instruction and its index
//            branch_valid/delta   - redirect relative to last accepted index
//            occupancy            - number of queued entries
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_unit #(
    parameter int IDX_W      = 32,
    parameter int INSTR_W    = 16,
    parameter int DEPTH      = 4,
    parameter int SWAP_BYTES = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     download_program,
    output logic                     mem_rd_en,
    output logic [IDX_W-1:0]         mem_index,
    input  logic [INSTR_W-1:0]       mem_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr,
    output logic [IDX_W-1:0]         instr_index,
    input  logic                     branch_valid,
    input  logic [IDX_W-1:0]         branch_delta,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int NB    = INSTR_W / 8;
    localparam logic [PTR_W+1:0] DEPTH_V = (PTR_W+2)'(DEPTH);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       fetch_idx;
    logic [IDX_W-1:0]       base_idx;
    logic [IDX_W-1:0]       inflight_idx;
    logic                   inflight;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W:0]         count;
    logic [INSTR_W-1:0]     q_data [DEPTH];
    logic [IDX_W-1:0]       q_idx  [DEPTH];

    logic [INSTR_W-1:0]     swapped;
    logic [PTR_W+1:0]       pending;
    logic                   handshake;

    // Byte order of each memory word is fixed at elaboration time.
    generate
        if (SWAP_BYTES != 0) begin : g_swap
            for (genvar k = 0; k < NB; k++) begin : g_byte
                assign swapped[8*k +: 8] = mem_data[8*(NB-1-k) +: 8];
            end
        end else begin : g_noswap
            assign swapped = mem_data;
        end
    endgenerate

    // Slots already committed: queued entries plus the read still in flight.
    assign pending = {1'b0, count} + (PTR_W+2)'(inflight);

    // Reset is folded in so no request is issued while reset is held.
    assign mem_rd_en = reset_n && (state == RUN) && !download_program &&
                       !branch_valid && (pending < DEPTH_V);
    assign mem_index = fetch_idx;

    // Hidden as soon as a download starts, before the flush takes effect.
    assign instr_valid = (count != '0) && (state == RUN) && !download_program;
    assign handshake   = instr_valid && instr_ready && !branch_valid;

    assign instr       = q_data[rd_ptr];
    assign instr_index = q_idx[rd_ptr];
    assign occupancy   = count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= RUN;
            fetch_idx    <= '0;
            base_idx     <= '0;
            inflight     <= 1'b0;
            inflight_idx <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_idx[i]  <= '0;
            end
        end else if (state == LOAD) begin
            // Hold everything empty; restart from index 0 on exit.
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            inflight  <= 1'b0;
            fetch_idx <= '0;
            if (!download_program) begin
                state <= RUN;
            end
        end else if (download_program) begin
            state     <= LOAD;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            inflight  <= 1'b0;
            fetch_idx <= '0;
        end else if (branch_valid) begin
            // Flush queue and drop the outstanding read; the returning
            // mem_data is never captured because inflight is cleared.
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            inflight  <= 1'b0;
            fetch_idx <= base_idx + branch_delta;
        end else begin
            inflight     <= mem_rd_en;
            inflight_idx <= fetch_idx;
            if (mem_rd_en) begin
                fetch_idx <= fetch_idx + IDX_W'(1);
            end
            if (inflight) begin
                q_data[wr_ptr] <= swapped;
                q_idx[wr_ptr]  <= inflight_idx;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (handshake) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                base_idx <= instr_index;
            end
            case ({inflight, handshake})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_prefetch_unit
// Purpose  : Scoreboard bench for prefetch_unit. Stimulus pushes expected
//            instruction indices into a queue; a monitor pops and compares
//            on every decode handshake. Memory returns 16'h0100+index one
//            cycle after each request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        download_program;
    logic        mem_rd_en;
    logic [31:0] mem_index;
    logic [15:0] mem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [31:0] instr_index;
    logic        branch_valid;
    logic [31:0] branch_delta;
    logic [2:0]  occupancy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    prefetch_unit #(
        .IDX_W      (32),
        .INSTR_W    (16),
        .DEPTH      (4),
        .SWAP_BYTES (1)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .download_program (download_program),
        .mem_rd_en        (mem_rd_en),
        .mem_index        (mem_index),
        .mem_data         (mem_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_index      (instr_index),
        .branch_valid     (branch_valid),
        .branch_delta     (branch_delta),
        .occupancy        (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [31:0] idx);
        return 16'h0100 + idx[15:0];
    endfunction

    // Decode sees the memory word with its two bytes exchanged.
    function automatic logic [15:0] exp_instr(input logic [31:0] idx);
        logic [15:0] w;
        w = mem_word(idx);
        return {w[7:0], w[15:8]};
    endfunction

    // Instruction memory: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= mem_word(mem_index);
    end

    // Monitor: every accepted head must match the next expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset_n && instr_valid && instr_ready && !branch_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pop: got index %0h instr %h, expected none",
                         instr_index, instr);
            end else begin
                e = exp_q.pop_front();
                if (instr_index !== e || instr !== exp_instr(e)) begin
                    failures++;
                    $display("FAIL pop: got index %0h instr %h, expected index %0h instr %h",
                             instr_index, instr, e, exp_instr(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_range(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(i));
    endtask

    // Hold instr_ready high until every expectation has been consumed.
    task automatic drain(input string name);
        int n;
        instr_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        download_program = 1'b0;
        instr_ready      = 1'b0;
        branch_valid     = 1'b0;
        branch_delta     = '0;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        check("rst_rd_en", 32'(mem_rd_en), 0);
        check("rst_mem_index", mem_index, 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_instr_index", instr_index, 0);
        check("rst_occupancy", 32'(occupancy), 0);

        // Straight-line fetch and first-request latency
        tick();
        reset_n = 1'b1;
        push_range(0, 8);
        instr_ready = 1'b1;
        @(negedge clk);
        check("first_rd_en", 32'(mem_rd_en), 1);
        check("first_mem_index", mem_index, 0);
        check("lat_valid_c0", 32'(instr_valid), 0);
        tick();
        @(negedge clk);
        check("lat_valid_c1", 32'(instr_valid), 0);
        tick();
        @(negedge clk);
        check("lat_valid_c2", 32'(instr_valid), 1);
        check("lat_index_c2", instr_index, 0);
        tick();
        drain("straight");
        instr_ready = 1'b0;

        // Backpressure: saturate then drain in order
        repeat (8) tick();
        @(negedge clk);
        check("bp_occupancy", 32'(occupancy), 4);
        check("bp_rd_en", 32'(mem_rd_en), 0);
        check("bp_head", instr_index, 8);
        tick();
        push_range(8, 6);
        drain("bp_drain");
        instr_ready = 1'b0;

        // Branch back: accept 14, then delta -3 targets 11
        repeat (8) tick();
        push_range(14, 1);
        instr_ready = 1'b1;
        tick();
        instr_ready  = 1'b0;
        branch_valid = 1'b1;
        branch_delta = -32'sd3;
        push_range(11, 3);
        @(negedge clk);
        check("br_rd_en", 32'(mem_rd_en), 0);
        tick();
        branch_valid = 1'b0;
        @(negedge clk);
        check("br_occupancy", 32'(occupancy), 0);
        check("br_valid", 32'(instr_valid), 0);
        tick();
        drain("br_back");

        // Branch with ready high and a read in flight; target wraps to
        // 0xFFFFFFFF from base 13.
        branch_valid = 1'b1;
        branch_delta = 32'hFFFF_FFF2;
        exp_q.push_back(32'hFFFF_FFFF);
        push_range(0, 2);
        @(negedge clk);
        check("brr_valid", 32'(instr_valid), 1);
        check("brr_rd_en", 32'(mem_rd_en), 0);
        tick();
        branch_valid = 1'b0;
        @(negedge clk);
        check("brr_occupancy", 32'(occupancy), 0);
        check("wrap_idx0", mem_index, 32'hFFFF_FFFF);
        check("wrap_rd_en0", 32'(mem_rd_en), 1);
        tick();
        @(negedge clk);
        check("wrap_idx1", mem_index, 0);
        tick();
        @(negedge clk);
        check("wrap_idx2", mem_index, 1);
        tick();
        drain("wrap");
        instr_ready = 1'b0;

        // Download pulse with a full queue
        repeat (8) tick();
        @(negedge clk);
        check("dl_full", 32'(occupancy), 4);
        tick();
        download_program = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dl_rd_en", 32'(mem_rd_en), 0);
            check("dl_valid", 32'(instr_valid), 0);
            tick();
        end
        download_program = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 4 && !seen; i++) begin
                @(negedge clk);
                if (mem_rd_en) begin
                    seen = 1'b1;
                    check("dl_first_index", mem_index, 0);
                end
                tick();
            end
            if (!seen) check("dl_resume", 0, 1);
        end
        push_range(0, 3);
        drain("dl_resume_drain");
        instr_ready = 1'b0;

        // Reset asserted together with a branch
        repeat (3) tick();
        reset_n      = 1'b0;
        branch_valid = 1'b1;
        branch_delta = 32'd5;
        @(negedge clk);
        check("rstbr_rd_en", 32'(mem_rd_en), 0);
        tick();
        branch_valid = 1'b0;
        @(negedge clk);
        check("rstbr_occupancy", 32'(occupancy), 0);
        check("rstbr_valid", 32'(instr_valid), 0);
        check("rstbr_instr", 32'(instr), 0);
        tick();
        reset_n = 1'b1;
        push_range(0, 3);
        drain("rstbr_drain");
        instr_ready = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
